// File: rtl/vga_sync_gen.sv
// Parametrised VGA raster timing generator with integer pixel-clock divider.
// Define VGA_FRAME_COUNT_EN to build the completed-frame counter; otherwise frame_count is 0.
module vga_sync_gen #(
  parameter int H_ACTIVE   = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter int H_SYNC_POL = 0,
  parameter int V_SYNC_POL = 0,
  parameter int CLK_DIV    = 1,
  parameter int FRAME_W    = 8,
  localparam int H_TOTAL   = H_ACTIVE + H_FP + H_SYNC + H_BP,
  localparam int V_TOTAL   = V_ACTIVE + V_FP + V_SYNC + V_BP,
  localparam int HW        = $clog2(H_TOTAL),
  localparam int VW        = $clog2(V_TOTAL)
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic [HW-1:0]      hpos,
  output logic [VW-1:0]      vpos,
  output logic               hsync,
  output logic               vsync,
  output logic               display_on,
  output logic               pix_tick,
  output logic               line_start,
  output logic               frame_start,
  output logic [FRAME_W-1:0] frame_count
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
  localparam logic HS_ON = (H_SYNC_POL != 0);
  localparam logic VS_ON = (V_SYNC_POL != 0);
  localparam int HS_START = H_ACTIVE + H_FP;
  localparam int HS_END   = HS_START + H_SYNC - 1;
  localparam int VS_START = V_ACTIVE + V_FP;
  localparam int VS_END   = VS_START + V_SYNC - 1;

  logic [DW-1:0] div_q, div_d;
  logic [HW-1:0] hpos_q, hpos_d;
  logic [VW-1:0] vpos_q, vpos_d;
  logic          hsync_q, hsync_d;
  logic          vsync_q, vsync_d;
  logic          display_on_q, display_on_d;
  logic          line_start_q, line_start_d;
  logic          frame_start_q, frame_start_d;

  assign pix_tick = (div_q == DIV_LAST);

  // Flag outputs are decoded from the next position so they line up with hpos/vpos.
  always_comb begin
    div_d  = pix_tick ? '0 : div_q + 1'b1;
    hpos_d = hpos_q;
    vpos_d = vpos_q;
    if (pix_tick) begin
      if (hpos_q == H_LAST) begin
        hpos_d = '0;
        vpos_d = (vpos_q == V_LAST) ? '0 : vpos_q + 1'b1;
      end else begin
        hpos_d = hpos_q + 1'b1;
      end
    end
    hsync_d = ((int'(hpos_d) >= HS_START) && (int'(hpos_d) <= HS_END)) ? HS_ON : ~HS_ON;
    vsync_d = ((int'(vpos_d) >= VS_START) && (int'(vpos_d) <= VS_END)) ? VS_ON : ~VS_ON;
    display_on_d  = (int'(hpos_d) < H_ACTIVE) && (int'(vpos_d) < V_ACTIVE);
    // Gating with pix_tick keeps the strobes one clock wide when CLK_DIV > 1.
    line_start_d  = pix_tick && (hpos_d == '0);
    frame_start_d = line_start_d && (vpos_d == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q         <= '0;
      hpos_q        <= H_LAST;
      vpos_q        <= V_LAST;
      hsync_q       <= ~HS_ON;
      vsync_q       <= ~VS_ON;
      display_on_q  <= 1'b0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      div_q         <= div_d;
      hpos_q        <= hpos_d;
      vpos_q        <= vpos_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      display_on_q  <= display_on_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign hpos        = hpos_q;
  assign vpos        = vpos_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign display_on  = display_on_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;

`ifdef VGA_FRAME_COUNT_EN
  logic [FRAME_W-1:0] frame_count_q, frame_count_d;
  logic               armed_q, armed_d;

  // The first frame_start after reset opens frame 0 and is not a completed frame.
  always_comb begin
    armed_d       = armed_q | frame_start_d;
    frame_count_d = (frame_start_d && armed_q) ? frame_count_q + 1'b1 : frame_count_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_count_q <= '0;
      armed_q       <= 1'b0;
    end else begin
      frame_count_q <= frame_count_d;
      armed_q       <= armed_d;
    end
  end

  assign frame_count = frame_count_q;
`else
  assign frame_count = '0;
`endif

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen: default, small (FRAME_W=2, active-high hsync) and CLK_DIV=2 instances
// checked against an arithmetic raster model, a hand-derived vector table and corner sequences.
module tb_vga_sync_gen;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    int   hpos;
    int   vpos;
    logic hsync;
    logic vsync;
    logic disp;
    logic pix;
    logic ls;
    logic fs;
    int   fc;
  } exp_t;

  typedef struct packed {
    int   e;
    exp_t x;
  } vec_t;

  // default timing
  logic [9:0] d_hpos, d_vpos;
  logic       d_hsync, d_vsync, d_disp, d_pix, d_ls, d_fs;
  logic [7:0] d_fc;
  // small timing H 8/1/2/1, V 4/1/1/1, hsync active-high, FRAME_W=2
  logic [3:0] s_hpos;
  logic [2:0] s_vpos;
  logic       s_hsync, s_vsync, s_disp, s_pix, s_ls, s_fs;
  logic [1:0] s_fc;
  // CLK_DIV=2, H 16/2/4/2, V 8/1/2/1, vsync active-high
  logic [4:0] c_hpos;
  logic [3:0] c_vpos;
  logic       c_hsync, c_vsync, c_disp, c_pix, c_ls, c_fs;
  logic [7:0] c_fc;

  vga_sync_gen u_def (
    .clk(clk), .rst_n(rst_n), .hpos(d_hpos), .vpos(d_vpos), .hsync(d_hsync), .vsync(d_vsync),
    .display_on(d_disp), .pix_tick(d_pix), .line_start(d_ls), .frame_start(d_fs), .frame_count(d_fc)
  );

  vga_sync_gen #(
    .H_ACTIVE(8), .H_FP(1), .H_SYNC(2), .H_BP(1), .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .H_SYNC_POL(1), .V_SYNC_POL(0), .CLK_DIV(1), .FRAME_W(2)
  ) u_small (
    .clk(clk), .rst_n(rst_n), .hpos(s_hpos), .vpos(s_vpos), .hsync(s_hsync), .vsync(s_vsync),
    .display_on(s_disp), .pix_tick(s_pix), .line_start(s_ls), .frame_start(s_fs), .frame_count(s_fc)
  );

  vga_sync_gen #(
    .H_ACTIVE(16), .H_FP(2), .H_SYNC(4), .H_BP(2), .V_ACTIVE(8), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .H_SYNC_POL(0), .V_SYNC_POL(1), .CLK_DIV(2), .FRAME_W(8)
  ) u_div (
    .clk(clk), .rst_n(rst_n), .hpos(c_hpos), .vpos(c_vpos), .hsync(c_hsync), .vsync(c_vsync),
    .display_on(c_disp), .pix_tick(c_pix), .line_start(c_ls), .frame_start(c_fs), .frame_count(c_fc)
  );

  int   checks = 0;
  int   errors = 0;
  int   e = 0;        // clock edges since reset release
  bit   mon_en = 1'b0;

  // Raster model: after e edges, n = e/cd pixel ticks have happened; tick n lands on linear pixel n-1.
  function automatic exp_t model(input int ee, input int ha, input int hfp, input int hs, input int hbp,
                                 input int va, input int vfp, input int vs, input int vbp,
                                 input int hpol, input int vpol, input int cd, input int fw);
    exp_t m;
    int ht = ha + hfp + hs + hbp;
    int vt = va + vfp + vs + vbp;
    int n = ee / cd;
    int l;
    bit fresh;
    bit in_h, in_v;
    m.pix = ((ee % cd) == cd - 1);
    if (n == 0) begin
      m.hpos = ht - 1;
      m.vpos = vt - 1;
      fresh  = 1'b0;
      m.fc   = 0;
    end else begin
      l      = (n - 1) % (ht * vt);
      m.hpos = l % ht;
      m.vpos = l / ht;
      fresh  = ((ee % cd) == 0);
      m.fc   = ((n - 1) / (ht * vt)) % (1 << fw);
    end
`ifndef VGA_FRAME_COUNT_EN
    m.fc = 0;
`endif
    in_h    = (m.hpos >= ha + hfp) && (m.hpos < ha + hfp + hs);
    in_v    = (m.vpos >= va + vfp) && (m.vpos < va + vfp + vs);
    m.hsync = in_h ? (hpol != 0) : (hpol == 0);
    m.vsync = in_v ? (vpol != 0) : (vpol == 0);
    m.disp  = (m.hpos < ha) && (m.vpos < va);
    m.ls    = fresh && (m.hpos == 0);
    m.fs    = m.ls && (m.vpos == 0);
    return m;
  endfunction

  function automatic exp_t act(input int hp, input int vp, input logic hs, input logic vs, input logic de,
                               input logic pt, input logic ls, input logic fs, input int fc);
    exp_t a;
    a.hpos = hp; a.vpos = vp; a.hsync = hs; a.vsync = vs; a.disp = de;
    a.pix = pt; a.ls = ls; a.fs = fs; a.fc = fc;
    return a;
  endfunction

  function automatic vec_t row(input int ee, input int hp, input int vp, input logic hs, input logic de,
                               input logic ls, input logic fs);
    vec_t r;
    r.e = ee;
    r.x = act(hp, vp, hs, 1'b1, de, 1'b1, ls, fs, 0);
    return r;
  endfunction

  task automatic chk(input string nm, input exp_t got, input exp_t req);
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL %s e=%0d got h=%0d v=%0d hs=%0b vs=%0b de=%0b pt=%0b ls=%0b fs=%0b fc=%0d required h=%0d v=%0d hs=%0b vs=%0b de=%0b pt=%0b ls=%0b fs=%0b fc=%0d",
               nm, e, got.hpos, got.vpos, got.hsync, got.vsync, got.disp, got.pix, got.ls, got.fs, got.fc,
               req.hpos, req.vpos, req.hsync, req.vsync, req.disp, req.pix, req.ls, req.fs, req.fc);
    end
  endtask

  task automatic chk_int(input string nm, input int got, input int req);
    checks++;
    if (got != req) begin
      errors++;
      $display("FAIL %s e=%0d got %0d required %0d", nm, e, got, req);
    end
  endtask

  function automatic exp_t d_act();
    return act(int'(d_hpos), int'(d_vpos), d_hsync, d_vsync, d_disp, d_pix, d_ls, d_fs, int'(d_fc));
  endfunction

  task automatic do_reset(input int cycles);
    @(posedge clk);
    #2 rst_n = 1'b0;
    repeat (cycles) @(negedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    vec_t tv[12];
    int   idx;
    int   cnt;
    bit   found;
    logic prev_pix;

    tv[0]  = row(0,   799, 524, 1'b1, 1'b0, 1'b0, 1'b0);
    tv[1]  = row(1,   0,   0,   1'b1, 1'b1, 1'b1, 1'b1);
    tv[2]  = row(2,   1,   0,   1'b1, 1'b1, 1'b0, 1'b0);
    tv[3]  = row(640, 639, 0,   1'b1, 1'b1, 1'b0, 1'b0);
    tv[4]  = row(641, 640, 0,   1'b1, 1'b0, 1'b0, 1'b0);
    tv[5]  = row(656, 655, 0,   1'b1, 1'b0, 1'b0, 1'b0);
    tv[6]  = row(657, 656, 0,   1'b0, 1'b0, 1'b0, 1'b0);
    tv[7]  = row(752, 751, 0,   1'b0, 1'b0, 1'b0, 1'b0);
    tv[8]  = row(753, 752, 0,   1'b1, 1'b0, 1'b0, 1'b0);
    tv[9]  = row(800, 799, 0,   1'b1, 1'b0, 1'b0, 1'b0);
    tv[10] = row(801, 0,   1,   1'b1, 1'b1, 1'b1, 1'b0);
    tv[11] = row(802, 1,   1,   1'b1, 1'b1, 1'b0, 1'b0);

    fork
      forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) e = 0;
        else e++;
      end
      forever begin
        @(negedge clk);
        if (mon_en) begin
          chk("model_def", d_act(), model(e, 640, 16, 96, 48, 480, 10, 2, 33, 0, 0, 1, 8));
          chk("model_small", act(int'(s_hpos), int'(s_vpos), s_hsync, s_vsync, s_disp, s_pix, s_ls, s_fs, int'(s_fc)),
              model(e, 8, 1, 2, 1, 4, 1, 1, 1, 1, 0, 1, 2));
          chk("model_div", act(int'(c_hpos), int'(c_vpos), c_hsync, c_vsync, c_disp, c_pix, c_ls, c_fs, int'(c_fc)),
              model(e, 16, 2, 4, 2, 8, 1, 2, 1, 0, 1, 2, 8));
        end
      end
    join_none

    // Table: reset values, then hand-derived default-timing points across the first line and wrap.
    repeat (2) @(negedge clk);
    mon_en = 1'b1;
    @(negedge clk);
    chk("tbl_reset", d_act(), tv[0].x);
    #1 rst_n = 1'b1;
    idx = 1;
    for (int cyc = 0; cyc < 900 && idx < 12; cyc++) begin
      @(negedge clk);
      if (e == tv[idx].e) begin
        chk($sformatf("tbl_e%0d", tv[idx].e), d_act(), tv[idx].x);
        idx++;
      end
    end
    chk_int("tbl_timeout", idx, 12);

    // Small instance: frame period and completed-frame counter at successive frame_start pulses.
    do_reset(2);
    for (int k = 0; k < 5; k++) begin
      found = 1'b0;
      cnt = 0;
      for (int t = 0; t < 200; t++) begin
        @(negedge clk);
        cnt++;
        if (s_fs) begin
          found = 1'b1;
          break;
        end
      end
      chk_int("small_fs_seen", int'(found), 1);
      if (k > 0) begin
        chk_int("small_frame_period", cnt, 84);
`ifdef VGA_FRAME_COUNT_EN
        chk_int("small_frame_count", int'(s_fc), k % 4);
`else
        chk_int("small_frame_count", int'(s_fc), 0);
`endif
      end
    end

    // CLK_DIV=2 instance: one-clock frame_start, alternating pix_tick, 576-clock frame period.
    do_reset(1);
    found = 1'b0;
    for (int t = 0; t < 10; t++) begin
      @(negedge clk);
      if (c_fs) begin
        found = 1'b1;
        break;
      end
    end
    chk_int("div_first_fs", int'(found), 1);
    chk_int("div_first_fs_edge", e, 2);
    prev_pix = c_pix;
    cnt = 0;
    found = 1'b0;
    for (int t = 0; t < 1000; t++) begin
      @(negedge clk);
      cnt++;
      if (cnt == 1) begin
        chk_int("div_fs_width", int'(c_fs), 0);
        chk_int("div_pix_alt", int'(c_pix), int'(!prev_pix));
      end
      if (c_fs) begin
        found = 1'b1;
        break;
      end
    end
    chk_int("div_fs_seen", int'(found), 1);
    chk_int("div_frame_period", cnt, 576);

    // Mid-frame asynchronous reset: outputs return to reset values before the next clock edge.
    found = 1'b0;
    for (int t = 0; t < 2000; t++) begin
      @(negedge clk);
      if (d_hpos == 10'd300 && d_vpos == 10'd1) begin
        found = 1'b1;
        break;
      end
    end
    chk_int("mid_reach_300_1", int'(found), 1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_reset_def", d_act(), tv[0].x);
    chk_int("mid_reset_small_fc", int'(s_fc), 0);
    chk_int("mid_reset_small_hsync", int'(s_hsync), 0);
    chk_int("mid_reset_div_vsync", int'(c_vsync), 0);
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("mid_restart_def", d_act(), tv[1].x);

    // Random run lengths and reset pulses; the model monitor checks every cycle.
    for (int r = 0; r < 6; r++) begin
      repeat ($urandom_range(20, 1500)) @(negedge clk);
      @(posedge clk);
      #($urandom_range(1, 4)) rst_n = 1'b0;
      repeat ($urandom_range(1, 3)) @(negedge clk);
      #1 rst_n = 1'b1;
    end
    repeat (300) @(negedge clk);

    mon_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
